// File: rtl/gsc_ctrl.sv
// gsc_ctrl: debounced keys and timed auto-advance drive frame-synchronous background select and green-screen enable
module gsc_ctrl #(
    parameter logic [19:0] DEB_CYCLES  = 20'd500000,
    parameter logic [7:0]  AUTO_FRAMES = 8'd120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] row,
    input  logic [12:0] col,
    input  logic        key_next,
    input  logic        key_en,
    input  logic        auto_mode,
    output logic        gsc_en,
    output logic [3:0]  gs_bg_sel,
    output logic [1:0]  bg_idx,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    logic [1:0] keys;
    logic [1:0] press;
    assign keys = {key_en, key_next};

    genvar k;
    generate
        for (k = 0; k < 2; k++) begin : g_deb
            logic [19:0] cnt_q, cnt_d;
            logic        press_q, press_d;
            // count while held, saturate, and pulse once on the cycle the count reaches the threshold
            always_comb begin
                cnt_d   = !keys[k] ? '0 : (cnt_q == DEB_CYCLES ? cnt_q : cnt_q + 20'd1);
                press_d = keys[k] && (cnt_q == DEB_CYCLES - 20'd1);
            end
            // debounce state
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end
            assign press[k] = press_q;
        end
    endgenerate

    logic       origin;
    logic       org_q, fs_q;
    logic [7:0] fc_q, fc_d;
    logic       auto_req;
    assign origin   = (row == '0) && (col == '0);
    assign auto_req = auto_mode && fs_q && (fc_q == AUTO_FRAMES - 8'd1);

    // frame counter wraps on the auto-advance frame and idles at zero when auto mode is off
    always_comb begin
        fc_d = !auto_mode ? 8'd0 : (!fs_q ? fc_q : (auto_req ? 8'd0 : fc_q + 8'd1));
    end

    // frame-start edge detect on the pixel origin, plus the frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            org_q <= 1'b0;
            fs_q  <= 1'b0;
            fc_q  <= '0;
        end else begin
            org_q <= origin;
            fs_q  <= origin && !org_q;
            fc_q  <= fc_d;
        end
    end

    logic [1:0] state_q, state_d;
    logic       adv_q, adv_d, tog_q, tog_d;
    logic [1:0] bg_q, bg_d;
    logic [3:0] sel_q, sel_d;
    logic       en_q, en_d, busy_q, busy_d;
    logic       ev_adv, ev_tog, adv_m, tog_m;
    assign ev_adv = press[0] || auto_req;
    assign ev_tog = press[1];
    assign adv_m  = adv_q || ev_adv;
    assign tog_m  = tog_q ^ ev_tog;

    // IDLE and LOAD both restart pending flags from fresh events; PEND merges them and commits on frame start
    always_comb begin
        state_d = state_q;
        adv_d   = adv_q;
        tog_d   = tog_q;
        bg_d    = bg_q;
        sel_d   = 4'b0000;
        en_d    = en_q;
        if (state_q == PEND) begin
            adv_d = adv_m;
            tog_d = tog_m;
            if (fs_q) begin
                state_d = LOAD;
                bg_d    = bg_q + {1'b0, adv_m};
                sel_d   = adv_m ? (4'b0001 << (bg_q + {1'b0, adv_m})) : 4'b0000;
                en_d    = en_q ^ tog_m;
                adv_d   = 1'b0;
                tog_d   = 1'b0;
            end
        end else begin
            state_d = (ev_adv || ev_tog) ? PEND : IDLE;
            adv_d   = ev_adv;
            tog_d   = ev_tog;
        end
        busy_d = state_d != IDLE;
    end

    // controller state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adv_q   <= 1'b0;
            tog_q   <= 1'b0;
            bg_q    <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adv_q   <= adv_d;
            tog_q   <= tog_d;
            bg_q    <= bg_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign gsc_en    = en_q;
    assign gs_bg_sel = sel_q;
    assign bg_idx    = bg_q;
    assign busy      = busy_q;
endmodule
